// File: rtl/vx_index_pool_if.sv
`default_nettype none
// ============================================================================
// vx_index_pool_if : acquire/read/release bus of the index pool
// Rev 1.0
// ============================================================================
interface vx_index_pool_if #(
  parameter int DATAW = 1,
  parameter int ADDRW = 2,
  parameter int CNTW  = 3
);
  logic             acquire_en;
  logic [DATAW-1:0] write_data;
  logic [ADDRW-1:0] acquire_addr;
  logic [ADDRW-1:0] read_addr;
  logic [DATAW-1:0] read_data;
  logic             release_en;
  logic [ADDRW-1:0] release_addr;
  logic [CNTW-1:0]  count;
  logic             empty;
  logic             full;
  logic             error;

  modport master (
    output acquire_en, write_data, read_addr, release_en, release_addr,
    input  acquire_addr, read_data, count, empty, full, error
  );

  modport slave (
    input  acquire_en, write_data, read_addr, release_en, release_addr,
    output acquire_addr, read_data, count, empty, full, error
  );
endinterface
`default_nettype wire

// File: rtl/vx_index_pool.sv
`default_nettype none
// ============================================================================
// vx_index_pool : lowest-free index allocator with per-entry payload storage
// Rev 1.0
// ============================================================================
module vx_index_pool #(
  parameter int DATAW   = 1,
  parameter int SIZE    = 4,
  parameter int OUT_REG = 0,
  parameter int ADDRW   = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int CNTW    = $clog2(SIZE + 1)
) (
  input  wire logic        clk,
  input  wire logic        reset,
  vx_index_pool_if.slave   bus
);
  localparam logic [CNTW-1:0]  c_SIZE_CNT  = CNTW'(SIZE);
  localparam logic [ADDRW:0]   c_SIZE_ADDR = (ADDRW+1)'(SIZE);

  logic [SIZE-1:0]  r_alloc;
  logic [CNTW-1:0]  r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_error;
  logic [DATAW-1:0] r_mem [SIZE];

  logic [ADDRW-1:0] w_acq_addr;
  logic             w_acq_ok;
  logic             w_rel_inr;
  logic             w_rel_ok;
  logic             w_err_set;
  logic [SIZE-1:0]  w_alloc_nxt;
  logic [CNTW-1:0]  w_cnt_nxt;

  // Descending scan so the lowest clear bit wins; all-set falls through to 0.
  always_comb begin
    w_acq_addr = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!r_alloc[i]) w_acq_addr = ADDRW'(i);
    end
  end

  assign w_acq_ok  = bus.acquire_en && !r_full;
  assign w_rel_inr = ({1'b0, bus.release_addr} < c_SIZE_ADDR);
  assign w_rel_ok  = bus.release_en && w_rel_inr && r_alloc[bus.release_addr];
  assign w_err_set = (bus.acquire_en && r_full) || (bus.release_en && !w_rel_ok);

  always_comb begin
    w_alloc_nxt = r_alloc;
    if (w_rel_ok) w_alloc_nxt[bus.release_addr] = 1'b0;
    if (w_acq_ok) w_alloc_nxt[w_acq_addr] = 1'b1;
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_acq_ok && !w_rel_ok)      w_cnt_nxt = r_count + CNTW'(1);
    else if (!w_acq_ok && w_rel_ok) w_cnt_nxt = r_count - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_alloc <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_alloc <= w_alloc_nxt;
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == c_SIZE_CNT);
      r_error <= r_error | w_err_set;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && w_acq_ok) r_mem[w_acq_addr] <= bus.write_data;
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATAW-1:0] r_rdata;
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_rdata <= '0;
        end else if (w_acq_ok && (w_acq_addr == bus.read_addr)) begin
          r_rdata <= bus.write_data;
        end else begin
          r_rdata <= r_mem[bus.read_addr];
        end
      end
      assign bus.read_data = r_rdata;
    end else begin : g_out_comb
      assign bus.read_data = r_mem[bus.read_addr];
    end
  endgenerate

  assign bus.acquire_addr = w_acq_addr;
  assign bus.count        = r_count;
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.error        = r_error;
endmodule
`default_nettype wire

// File: tb/tb_vx_index_pool.sv
`default_nettype none
// ============================================================================
// tb_vx_index_pool : directed checks of both OUT_REG builds driven in lockstep
// Rev 1.0
// ============================================================================
module tb_vx_index_pool;
  logic       clk;
  logic       reset;
  logic       acq_en;
  logic [7:0] wdata;
  logic [1:0] raddr;
  logic       rel_en;
  logic [1:0] rel_addr;

  int total = 0;
  int bad   = 0;
  logic [7:0] q_reg[$];

  vx_index_pool_if #(.DATAW(8), .ADDRW(2), .CNTW(3)) bus0 ();
  vx_index_pool_if #(.DATAW(8), .ADDRW(2), .CNTW(3)) bus1 ();

  assign bus0.acquire_en = acq_en;   assign bus1.acquire_en = acq_en;
  assign bus0.write_data = wdata;    assign bus1.write_data = wdata;
  assign bus0.read_addr  = raddr;    assign bus1.read_addr  = raddr;
  assign bus0.release_en = rel_en;   assign bus1.release_en = rel_en;
  assign bus0.release_addr = rel_addr; assign bus1.release_addr = rel_addr;

  vx_index_pool #(.DATAW(8), .SIZE(4), .OUT_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  vx_index_pool #(.DATAW(8), .SIZE(4), .OUT_REG(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input bit emp,
                           input bit ful, input bit err, input int aa);
    chk({tag, " cnt0"}, 32'(bus0.count), 32'(cnt));
    chk({tag, " cnt1"}, 32'(bus1.count), 32'(cnt));
    chk({tag, " empty0"}, 32'(bus0.empty), 32'(emp));
    chk({tag, " empty1"}, 32'(bus1.empty), 32'(emp));
    chk({tag, " full0"}, 32'(bus0.full), 32'(ful));
    chk({tag, " full1"}, 32'(bus1.full), 32'(ful));
    chk({tag, " err0"}, 32'(bus0.error), 32'(err));
    chk({tag, " err1"}, 32'(bus1.error), 32'(err));
    chk({tag, " aaddr0"}, 32'(bus0.acquire_addr), 32'(aa));
    chk({tag, " aaddr1"}, 32'(bus1.acquire_addr), 32'(aa));
  endtask

  // One clock; registered-read expectations pushed in the prior cycle are popped here.
  task automatic tick();
    @(posedge clk);
    #1;
    if (q_reg.size() > 0) chk("rd_reg", 32'(bus1.read_data), 32'(q_reg.pop_front()));
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp_comb, input logic [7:0] exp_reg);
    raddr = a;
    #1;
    chk("rd_comb", 32'(bus0.read_data), 32'(exp_comb));
    q_reg.push_back(exp_reg);
  endtask

  initial begin
    reset = 1'b0; acq_en = 1'b0; wdata = '0; raddr = '0; rel_en = 1'b0; rel_addr = '0;
    tick(); tick();
    chk_state("reset", 0, 1, 0, 0, 0);
    chk("reset rd_reg", 32'(bus1.read_data), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      chk("fill aaddr", 32'(bus0.acquire_addr), 32'(i));
      acq_en = 1'b1; wdata = 8'hA0 + 8'(i);
      tick();
    end
    acq_en = 1'b0;
    chk_state("full", 4, 0, 1, 0, 0);
    rd(2'd2, 8'hA2, 8'hA2); tick();
    rd(2'd0, 8'hA0, 8'hA0); tick();

    rel_en = 1'b1; rel_addr = 2'd1; tick();
    chk_state("rel1", 3, 0, 0, 0, 1);
    rel_addr = 2'd3; tick();
    rel_en = 1'b0;
    chk_state("rel3", 2, 0, 0, 0, 1);

    // Freed entry 1 still holds A1; the reg path sees the same-edge write.
    acq_en = 1'b1; wdata = 8'hB1;
    rd(2'd1, 8'hA1, 8'hB1);
    tick();
    acq_en = 1'b0;
    chk("rd_comb new", 32'(bus0.read_data), 32'hB1);
    chk_state("reacq1", 3, 0, 0, 0, 3);
    acq_en = 1'b1; wdata = 8'hB3; tick();
    acq_en = 1'b0;
    chk_state("reacq3", 4, 0, 1, 0, 0);

    acq_en = 1'b1; wdata = 8'hEE; rel_en = 1'b1; rel_addr = 2'd0; tick();
    acq_en = 1'b0; rel_en = 1'b0;
    chk_state("full acq+rel", 3, 0, 0, 1, 0);
    rd(2'd0, 8'hA0, 8'hA0); tick();
    rd(2'd3, 8'hB3, 8'hB3); tick();

    reset = 1'b0; acq_en = 1'b1; rel_en = 1'b1; rel_addr = 2'd1; tick();
    chk_state("midreset", 0, 1, 0, 0, 0);
    chk("midreset rd_reg", 32'(bus1.read_data), 32'h0);
    reset = 1'b1; acq_en = 1'b0; rel_en = 1'b0;

    acq_en = 1'b1; wdata = 8'hC0; tick();
    wdata = 8'hC1; tick();
    acq_en = 1'b0;
    chk_state("two", 2, 0, 0, 0, 2);

    acq_en = 1'b1; wdata = 8'hC2; rel_en = 1'b1; rel_addr = 2'd0; tick();
    acq_en = 1'b0; rel_en = 1'b0;
    chk_state("acq+rel", 2, 0, 0, 0, 0);
    acq_en = 1'b1; wdata = 8'hD0; tick();
    acq_en = 1'b0;
    chk_state("after swap", 3, 0, 0, 0, 3);
    rd(2'd2, 8'hC2, 8'hC2); tick();
    rd(2'd0, 8'hD0, 8'hD0); tick();

    rel_en = 1'b1; rel_addr = 2'd3; tick();
    rel_en = 1'b0;
    chk_state("rel free", 3, 0, 0, 1, 3);
    tick(); tick(); tick();
    chk_state("err held", 3, 0, 0, 1, 3);

    acq_en = 1'b1; wdata = 8'hD3; tick();
    chk_state("refull", 4, 0, 1, 1, 0);
    tick();
    acq_en = 1'b0;
    chk_state("acq full", 4, 0, 1, 1, 0);
    rd(2'd3, 8'hD3, 8'hD3); tick();

    rel_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rel_addr = 2'(i);
      tick();
    end
    rel_en = 1'b0;
    chk_state("drained", 0, 1, 0, 1, 0);

    reset = 1'b0; tick();
    reset = 1'b1;
    chk_state("final reset", 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vx_index_pool.md
VX_INDEX_POOL -- requirements
Module: VX_index_pool

Interface
REQ-001 SHALL have parameter DATAW, default 1: payload width in bits per entry.
REQ-002 SHALL have parameter SIZE, default 4: number of entries, >= 2.
REQ-003 SHALL have parameter OUT_REG, default 0: read latency, 0 = combinational, 1 = registered.
REQ-004 SHALL have parameter ADDRW, default LOG2UP(SIZE): index width.
REQ-005 SHALL have parameter CNTW, default LOG2UP(SIZE+1): occupancy count width.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset asserted).
REQ-008 SHALL have port acquire_en, input, 1: allocate the entry at acquire_addr and store write_data into it.
REQ-009 SHALL have port write_data, input, DATAW: payload stored on an accepted acquire.
REQ-010 SHALL have port acquire_addr, output, ADDRW: lowest-numbered free index, combinational from current state.
REQ-011 SHALL have port read_addr, input, ADDRW: index to read.
REQ-012 SHALL have port read_data, output, DATAW: payload of read_addr.
REQ-013 SHALL have port release_en, input, 1: free the entry at release_addr.
REQ-014 SHALL have port release_addr, input, ADDRW: index to free, independent of read_addr.
REQ-015 SHALL have port count, output, CNTW: number of allocated entries.
REQ-016 SHALL have ports empty and full, output, 1 each: count == 0 and count == SIZE.
REQ-017 SHALL have port error, output, 1: sticky flag for illegal requests.

Function
REQ-018 SHALL track one allocated bit per entry; acquire_addr SHALL equal the lowest index whose bit is clear, and 0 when full.
REQ-019 SHALL accept acquire_en only when full is 0 at the start of the cycle; the accepted acquire sets the bit and writes write_data at the next edge.
REQ-020 SHALL ignore acquire_en while full, including when release_en is asserted in the same cycle, and SHALL set error.
REQ-021 SHALL accept release_en when the bit at release_addr is set and clear that bit at the next edge; payload contents SHALL remain unchanged.
REQ-022 SHALL treat release of a clear entry, or release_addr >= SIZE, as a no-op that sets error.
REQ-023 SHALL handle accepted acquire and release in the same cycle as follows: both take effect, count is unchanged, empty and full are unchanged.
REQ-024 SHALL handle release_addr equal to acquire_addr in the same cycle (bit clear) per REQ-022: the release is illegal, the acquire proceeds, and error is set.
REQ-025 SHALL update count by +1 on acquire only, -1 on release only, and 0 on both or neither; count SHALL never exceed SIZE or underflow.
REQ-026 SHALL make empty, full and count registered values, valid from the cycle after the edge that changes them.
REQ-027 SHALL, with OUT_REG=0, drive read_data with the stored payload at read_addr in the same cycle; a same-cycle write to that index SHALL be visible next cycle.
REQ-028 SHALL, with OUT_REG=1, drive read_data with the payload at the read_addr sampled on the previous edge, using write-first ordering: a write on that edge to the same index returns the new write_data.
REQ-029 SHALL not depend on the allocated bit for reads; reading a free entry returns its stale payload.
REQ-030 SHALL keep error set until reset, once set.

Reset
REQ-031 SHALL, while reset == 0 at a rising edge, clear all allocated bits, count=0, empty=1, full=0, error=0, and acquire_addr=0; with OUT_REG=1, read_data SHALL be 0.
REQ-032 SHALL ignore acquire_en and release_en during reset cycles.
REQ-033 SHALL not reset payload storage; its contents are undefined until written.
REQ-034 SHALL, when reset is asserted mid-operation, discard all allocations; the first acquire after reset SHALL return index 0.

Verification (SIZE=4, DATAW=8)
REQ-035 SHALL cover: 4 acquires with data 0xA0..0xA3 -> acquire_addr 0,1,2,3; full=1, count=4; read_addr 2 -> 0xA2 (1 cycle later if OUT_REG=1).
REQ-036 SHALL cover: from full, release 1 then release 3 -> count=2; next acquire_addr=1, then 3.
REQ-037 SHALL cover: from full, acquire_en and release_en(0) in the same cycle -> acquire dropped, error=1, count=3, acquire_addr=0 next cycle.
REQ-038 SHALL cover: with 2 allocated, acquire plus release(0) in the same cycle -> count stays 2, new index 2 allocated, index 0 freed.
REQ-039 SHALL cover: release of a free index 3 -> no state change, error=1 and held until reset.
REQ-040 SHALL cover: reset low mid-sequence with count=3 -> count=0, empty=1, error=0; next acquire_addr=0; both OUT_REG values exercised.
